// File: rtl/arduino_note_tx_if.sv
// Signal bundle between the game control unit/datapath and the Arduino note transmitter.
interface arduino_note_tx_if;
  logic       activate_arduino;
  logic       select_mux_arduino;
  logic [3:0] nota_musica;
  logic [3:0] nota_jogador;
  logic       tx;
  logic       busy;
  logic [7:0] db_ultimo_byte;

  // Control unit / datapath side: drives note requests, observes the line.
  modport master (
    output activate_arduino,
    output select_mux_arduino,
    output nota_musica,
    output nota_jogador,
    input  tx,
    input  busy,
    input  db_ultimo_byte
  );

  // Transmitter side: consumes note requests, drives the UART line.
  modport slave (
    input  activate_arduino,
    input  select_mux_arduino,
    input  nota_musica,
    input  nota_jogador,
    output tx,
    output busy,
    output db_ultimo_byte
  );
endinterface

// File: rtl/arduino_note_tx.sv
// 8N1 UART transmitter that sends the current note command to the Arduino
// sound board whenever the requested command byte changes.
module arduino_note_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic             clock,
  input  logic             reset,
  arduino_note_tx_if.slave bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NOTA_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    START  = 2'd1,
    DADOS  = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [BYTE_W-1:0]   shift_q, shift_n;
  logic [BYTE_W-1:0]   ultimo_q, ultimo_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;

  logic [NOTA_W-1:0]   nota_c;
  logic [BYTE_W-1:0]   cmd_c;
  logic                bit_done_c;

  // Requested command byte; silence is encoded as 8'h00.
  always_comb begin
    nota_c = bus.select_mux_arduino ? bus.nota_musica : bus.nota_jogador;
    cmd_c  = '0;
    if (bus.activate_arduino) begin
      cmd_c = {1'b1, bus.select_mux_arduino, 2'b00, nota_c};
    end
  end

  // Next-state logic; tx/busy are derived from the next state so the
  // registered line level always matches the registered state.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    idx_n      = idx_q;
    shift_n    = shift_q;
    ultimo_n   = ultimo_q;
    tx_n       = 1'b1;
    busy_n     = 1'b0;
    bit_done_c = (cnt_q == CNT_LAST);

    case (state_q)
      OCIOSO: begin
        if (cmd_c != ultimo_q) begin
          state_n  = START;
          shift_n  = cmd_c;
          ultimo_n = cmd_c;
          cnt_n    = '0;
          idx_n    = '0;
        end
      end
      START: begin
        if (bit_done_c) begin
          state_n = DADOS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DADOS: begin
        if (bit_done_c) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift_q[BYTE_W-1:1]};
          idx_n   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Always return to idle for at least one cycle between frames.
        if (bit_done_c) begin
          state_n = OCIOSO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = OCIOSO;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DADOS:   tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != OCIOSO);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      ultimo_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      shift_q  <= shift_n;
      ultimo_q <= ultimo_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.tx             = tx_q;
  assign bus.busy           = busy_q;
  assign bus.db_ultimo_byte = ultimo_q;

endmodule

// File: tb/tb_arduino_note_tx.sv
// Self-checking bench for arduino_note_tx with CLKS_PER_BIT = 4.
module tb_arduino_note_tx;

  localparam int C = 4;

  logic clock;
  logic reset;
  arduino_note_tx_if bus();

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position within the current frame, -1 when idle.
  int         m_pos    = -1;
  logic [7:0] m_ultimo = 8'h00;
  logic [7:0] m_byte   = 8'h00;

  // Line decoder: bytes recovered from tx by mid-bit sampling.
  logic [7:0] rx_q[$];
  int         mon_cnt  = -1;
  logic [7:0] mon_byte = 8'h00;

  arduino_note_tx #(.CLKS_PER_BIT(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] model_cmd();
    if (!bus.activate_arduino) return 8'h00;
    return {1'b1, bus.select_mux_arduino, 2'b00,
            bus.select_mux_arduino ? bus.nota_musica : bus.nota_jogador};
  endfunction

  function automatic logic exp_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic exp_busy();
    return (m_pos >= 0);
  endfunction

  // Frame-level model: a frame is 10*C cycles; new frames only start from idle.
  always @(posedge clock) begin
    if (reset) begin
      m_pos    <= -1;
      m_ultimo <= 8'h00;
    end else if (m_pos < 0) begin
      if (model_cmd() != m_ultimo) begin
        m_ultimo <= model_cmd();
        m_byte   <= model_cmd();
        m_pos    <= 0;
      end
    end else if (m_pos == 10*C - 1) begin
      m_pos <= -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  // UART decoder on the DUT line; a frame cut short by busy falling is dropped.
  always @(negedge clock) begin
    if (mon_cnt >= 0 && bus.busy !== 1'b1) begin
      mon_cnt <= -1;
    end else if (mon_cnt < 0) begin
      if (bus.tx === 1'b0 && bus.busy === 1'b1) mon_cnt <= 1;
    end else begin
      if (mon_cnt % C == 1 && mon_cnt > C && mon_cnt < 9*C)
        mon_byte[mon_cnt/C - 1] <= bus.tx;
      if (mon_cnt == 9*C + 1) begin
        rx_q.push_back(mon_byte);
        mon_cnt <= -1;
      end else begin
        mon_cnt <= mon_cnt + 1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.activate_arduino   = 1'b0;
    bus.select_mux_arduino = 1'b0;
    bus.nota_musica        = 4'd0;
    bus.nota_jogador       = 4'd0;
    repeat (3) @(negedge clock);
    n_chk++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.db_ultimo_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values tx=%b busy=%b db=%h required 1 0 00", bus.tx, bus.busy, bus.db_ultimo_byte);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || rx_q.size() != 0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d tx=%b busy=%b frames=%0d required 1 0 0", k, bus.tx, bus.busy, rx_q.size());
      end
    end
  endtask

  task automatic test_memory_note();
    int busy_cycles;
    int q0;
    q0 = rx_q.size();
    bus.activate_arduino   = 1'b1;
    bus.select_mux_arduino = 1'b1;
    bus.nota_musica        = 4'd5;
    @(negedge clock);
    n_chk++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.db_ultimo_byte !== 8'hC5) begin
      n_fail++;
      $display("FAIL mem_first_edge tx=%b busy=%b db=%h required 0 1 C5", bus.tx, bus.busy, bus.db_ultimo_byte);
    end
    busy_cycles = 1;
    for (int k = 2; k <= 45; k++) begin
      @(negedge clock);
      if (bus.busy === 1'b1) busy_cycles++;
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL mem_note k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
    end
    n_chk++;
    if (busy_cycles != 40) begin
      n_fail++;
      $display("FAIL mem_busy_len busy_cycles=%0d required 40", busy_cycles);
    end
    n_chk++;
    if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hC5) begin
      n_fail++;
      $display("FAIL mem_frame frames=%0d required %0d byte C5", rx_q.size() - q0, 1);
    end
  endtask

  task automatic test_player_note();
    int q0;
    q0 = rx_q.size();
    bus.select_mux_arduino = 1'b0;
    bus.nota_jogador       = 4'd3;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL player_note k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
      if (k == 45) bus.activate_arduino = 1'b0;
    end
    n_chk++;
    if (rx_q.size() != q0 + 2 || rx_q[q0] !== 8'h83 || rx_q[q0+1] !== 8'h00) begin
      n_fail++;
      $display("FAIL player_frames count=%0d required 2 bytes 83 00", rx_q.size() - q0);
    end
  endtask

  task automatic test_coalesce();
    int q0;
    q0 = rx_q.size();
    bus.activate_arduino   = 1'b1;
    bus.select_mux_arduino = 1'b1;
    bus.nota_musica        = 4'd5;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL coalesce k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
      if (k == 41) begin
        n_chk++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL coalesce_gap tx=%b busy=%b required 1 0", bus.tx, bus.busy);
        end
      end
      if (k == 42) begin
        n_chk++;
        if (bus.busy !== 1'b1 || bus.db_ultimo_byte !== 8'hC9) begin
          n_fail++;
          $display("FAIL coalesce_second busy=%b db=%h required 1 C9", bus.busy, bus.db_ultimo_byte);
        end
      end
      if (k == 10) bus.nota_musica = 4'd7;
      if (k == 20) bus.nota_musica = 4'd9;
    end
    n_chk++;
    if (rx_q.size() != q0 + 2 || rx_q[q0] !== 8'hC5 || rx_q[q0+1] !== 8'hC9) begin
      n_fail++;
      $display("FAIL coalesce_frames count=%0d required 2 bytes C5 C9", rx_q.size() - q0);
    end
  endtask

  task automatic test_revert();
    int q0;
    q0 = rx_q.size();
    bus.nota_musica = 4'd5;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL revert k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
      if (k == 10) bus.nota_musica = 4'd7;
      if (k == 30) bus.nota_musica = 4'd5;
    end
    n_chk++;
    if (bus.busy !== 1'b0 || rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hC5) begin
      n_fail++;
      $display("FAIL revert_frames busy=%b count=%0d required 0 and 1 frame C5", bus.busy, rx_q.size() - q0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int q0;
    q0 = rx_q.size();
    bus.activate_arduino = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
      if (k == 60) begin
        n_chk++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.db_ultimo_byte !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_mid_abort tx=%b busy=%b db=%h required 1 0 00", bus.tx, bus.busy, bus.db_ultimo_byte);
        end
        reset = 1'b0;
      end
      if (k == 61) begin
        n_chk++;
        if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.db_ultimo_byte !== 8'hC5) begin
          n_fail++;
          $display("FAIL reset_mid_resend tx=%b busy=%b db=%h required 0 1 C5", bus.tx, bus.busy, bus.db_ultimo_byte);
        end
      end
      if (k == 45) bus.activate_arduino = 1'b1;
      if (k == 59) reset = 1'b1;
    end
    n_chk++;
    if (rx_q.size() != q0 + 2 || rx_q[q0] !== 8'h00 || rx_q[q0+1] !== 8'hC5) begin
      n_fail++;
      $display("FAIL reset_mid_frames count=%0d required 2 bytes 00 C5", rx_q.size() - q0);
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 2500; k++) begin
      @(negedge clock);
      n_chk++;
      if (bus.tx !== exp_tx() || bus.busy !== exp_busy() || bus.db_ultimo_byte !== m_ultimo) begin
        n_fail++;
        $display("FAIL random k=%0d tx=%b/%b busy=%b/%b db=%h/%h (actual/required)", k, bus.tx, exp_tx(), bus.busy, exp_busy(), bus.db_ultimo_byte, m_ultimo);
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      case ($urandom_range(0, 39))
        0: bus.activate_arduino   = ~bus.activate_arduino;
        1: bus.select_mux_arduino = ~bus.select_mux_arduino;
        2: bus.nota_musica        = 4'($urandom_range(0, 15));
        3: bus.nota_jogador       = 4'($urandom_range(0, 15));
        default: ;
      endcase
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.activate_arduino   = 1'b0;
    bus.select_mux_arduino = 1'b0;
    bus.nota_musica        = 4'd0;
    bus.nota_jogador       = 4'd0;
    test_reset();
    test_memory_note();
    test_player_note();
    test_coalesce();
    test_revert();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
